// File: rtl/dmem_responder_if.sv
// CPU-to-data-memory request/response bus: one request channel and one response channel,
// each with a valid/ready handshake.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory that answers one request at a time after WAIT_CYCLES wait states.
// Optional feature: define DMEM_BYTE_ENABLE_EN for per-byte write enables (otherwise writes are full-word).
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              pc_reset,
  dmem_responder_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES == 0) ? '0 : CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [31:0]   rsp_rdata_q;
  logic [31:0]   mem_q [DEPTH];

  logic          idle_c;
  logic          enter_resp_c;
  logic          cur_we_c;
  logic [31:0]   cur_addr_c;
  logic [31:0]   cur_wdata_c;
  logic [3:0]    cur_be_c;
  logic          cur_err_c;
  logic [AW-1:0] cur_idx_c;
  logic [3:0]    wmask_c;
  logic [31:0]   rd_word_c;
  logic [31:0]   wword_c;
  logic          commit_c;

  // In IDLE the request is taken straight from the bus so WAIT_CYCLES=0 can commit at acceptance.
  assign idle_c      = (state_q == IDLE);
  assign cur_we_c    = idle_c ? bus.req_we    : we_q;
  assign cur_addr_c  = idle_c ? bus.req_addr  : addr_q;
  assign cur_wdata_c = idle_c ? bus.req_wdata : wdata_q;
  assign cur_be_c    = idle_c ? bus.req_be    : be_q;

  assign cur_err_c = (cur_addr_c[1:0] != 2'b00) || (cur_addr_c[31:2] >= 30'(DEPTH));
  assign cur_idx_c = cur_addr_c[AW+1:2];
  assign rd_word_c = mem_q[cur_idx_c];

  assign enter_resp_c = (idle_c && bus.req_valid && (WAIT_CYCLES == 0)) ||
                        ((state_q == WAIT) && (cnt_q == '0));
  assign commit_c     = enter_resp_c && cur_we_c && !cur_err_c && !pc_reset;

`ifdef DMEM_BYTE_ENABLE_EN
  assign wmask_c = cur_be_c;
`else
  // Byte enables have no effect: every lane is forced on.
  assign wmask_c = cur_be_c | 4'hF;
`endif

  always_comb begin
    wword_c = rd_word_c;
    for (int i = 0; i < 4; i++) begin
      if (wmask_c[i]) wword_c[8*i +: 8] = cur_wdata_c[8*i +: 8];
    end
  end

  // Storage is never reset; contents persist across pc_reset.
  always_ff @(posedge clk) begin
    if (commit_c) mem_q[cur_idx_c] <= wword_c;
  end

  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (enter_resp_c) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= cur_err_c;
        rsp_rdata_q <= (cur_we_c || cur_err_c) ? '0 : rd_word_c;
      end
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
            cnt_q   <= CNT_INIT;
            state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = idle_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words in storage (power of two, 4..1024).
REQ-002 Parameter WAIT_CYCLES, default 2, extra wait states between request acceptance and response (0..15).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 pc_reset  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  CPU request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  write data.
REQ-010 req_be  input  4  byte enables, bit i covers wdata[8i+7:8i].
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  CPU accepts response.
REQ-013 rsp_rdata  output  32  read data, zero for writes and errors.
REQ-014 rsp_err  output  1  request was misaligned or out of range.

Function
REQ-015 FSM states: IDLE, WAIT, RESP. The FSM SHALL encode no other reachable state.
REQ-016 req_ready SHALL be 1 only in IDLE, decoded combinationally from state.
REQ-017 In IDLE, req_valid&req_ready at an edge SHALL capture we/addr/wdata/be and go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-018 WAIT SHALL load a down-counter with WAIT_CYCLES-1 on entry and go to RESP at the edge where the counter is 0.
REQ-019 Write commit and read sampling SHALL occur at the edge entering RESP; rsp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-020 In RESP, rsp_valid, rsp_rdata, and rsp_err SHALL be held stable until rsp_valid&rsp_ready; then go to IDLE.
REQ-021 A request presented in the same cycle as the RESP handshake SHALL NOT be accepted (one bubble cycle in IDLE).
REQ-022 Error if addr[1:0]!=0 or addr[31:2]>=DEPTH: rsp_err=1, rsp_rdata=0, no storage change.
REQ-023 Read of a word written by an earlier completed request SHALL return the written data.
REQ-024 rsp_valid, rsp_err, and rsp_rdata SHALL be 0 whenever the state is not RESP.

Reset
REQ-025 pc_reset SHALL immediately force IDLE, clear the counter, rsp_valid=0, rsp_err=0, and rsp_rdata=0, independent of clk.
REQ-026 Reset mid-transaction SHALL drop the pending response; a write not yet committed SHALL NOT be committed.
REQ-027 Storage contents SHALL NOT be cleared by reset; they are undefined after power-up until written.

Configuration
REQ-028 With DMEM_BYTE_ENABLE_EN defined, writes SHALL update only bytes with req_be bit set; a write with req_be=0 SHALL complete without error and change nothing.
REQ-029 Without DMEM_BYTE_ENABLE_EN, req_be SHALL be ignored and every write SHALL update the full word.

Verification
REQ-030 WAIT_CYCLES=2, write 0xDEADBEEF to 0x10, then read 0x10 -> each rsp_valid rises 3 cycles after acceptance; read rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-031 Read 0x13 and read 0x100 (DEPTH=64) -> rsp_err=1, rsp_rdata=0; a subsequent read of 0x10 is unchanged.
REQ-032 rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_rdata stable all 5 cycles; req_ready=0 throughout; a new request is accepted only in the cycle after the handshake.
REQ-033 pc_reset pulsed during WAIT of a write of 0x12345678 to 0x20 (previously 0xAAAAAAAA) -> rsp_valid never rises; read of 0x20 returns 0xAAAAAAAA.
REQ-034 With DMEM_BYTE_ENABLE_EN defined: 0x00000000 at 0x8, write 0xFFFFFFFF with be=0101 -> read 0x00FF00FF; without the macro -> read 0xFFFFFFFF.
REQ-035 WAIT_CYCLES=0, back-to-back reads with rsp_ready=1 -> rsp_valid one cycle after each acceptance, one request every 2 cycles.
